// File: rtl/hazard_stall_unit_if.sv
// Hazard stall unit pipeline-side bundle: hazard inputs from ID/EX/MEM plus hold/bubble/flush controls back out.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             mem_req;
  logic             mem_ready;
  logic             if_flush_in;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             exmem_hold;
  logic             if_flush_out;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  // Pipeline side: drives hazard sources, consumes stall controls
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_req, mem_ready, if_flush_in,
    input  pc_write, ifid_write, idex_bubble, exmem_hold,
           if_flush_out, stall_cycles, mem_timeout
  );

  // Stall unit side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_req, mem_ready, if_flush_in,
    output pc_write, ifid_write, idex_bubble, exmem_hold,
           if_flush_out, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hold/bubble controller: load-use bubbles, memory-busy freeze, deferred IF flush,
// saturating stall-cycle counter and sticky memory-timeout flag.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              reset_n,
  hazard_stall_unit_if.slave hz
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              flush_pending_q, flush_pending_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lu_c;
  logic mb_c;
  logic mem_done_c;
  logic pc_write_c;
  logic ifid_write_c;
  logic idex_bubble_c;
  logic exmem_hold_c;
  logic if_flush_out_c;

  // Hazard detection; a dropped mem_req while waiting counts as completion
  always_comb begin
    lu_c = hz.ex_memread & (hz.ex_rt != 5'd0) &
           ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
    mb_c       = hz.mem_req & ~hz.mem_ready;
    mem_done_c = hz.mem_ready | ~hz.mem_req;
  end

  // Next-state and Mealy control outputs
  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    wait_cnt_d      = wait_cnt_q;
    pc_write_c      = 1'b1;
    ifid_write_c    = 1'b1;
    idex_bubble_c   = 1'b0;
    exmem_hold_c    = 1'b0;
    if_flush_out_c  = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mb_c) begin
          pc_write_c      = 1'b0;
          ifid_write_c    = 1'b0;
          exmem_hold_c    = 1'b1;
          flush_pending_d = hz.if_flush_in;
          wait_cnt_d      = WAIT_W'(1);
          state_d         = S_MEM_WAIT;
        end else if (lu_c) begin
          // Branch in ID re-resolves after the bubble, so its flush is dropped
          pc_write_c      = 1'b0;
          ifid_write_c    = 1'b0;
          idex_bubble_c   = 1'b1;
          flush_pending_d = 1'b0;
          wait_cnt_d      = '0;
        end else begin
          if_flush_out_c  = hz.if_flush_in;
          flush_pending_d = 1'b0;
          wait_cnt_d      = '0;
        end
      end

      S_MEM_WAIT: begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        exmem_hold_c = 1'b1;
        if (mem_done_c) begin
          exmem_hold_c    = 1'b0;
          if_flush_out_c  = flush_pending_q | hz.if_flush_in;
          flush_pending_d = 1'b0;
          wait_cnt_d      = '0;
          state_d         = S_RUN;
          if (lu_c) begin
            idex_bubble_c = 1'b1;
          end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
          end
        end else begin
          flush_pending_d = flush_pending_q | hz.if_flush_in;
          wait_cnt_d      = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    if (!reset_n) begin
      pc_write_c     = 1'b0;
      ifid_write_c   = 1'b0;
      idex_bubble_c  = 1'b1;
      exmem_hold_c   = 1'b0;
      if_flush_out_c = 1'b0;
    end

    mem_timeout_d  = mem_timeout_q | ((state_d == S_MEM_WAIT) && (wait_cnt_d == WAIT_MAX));
    stall_cycles_d = (!pc_write_c && (stall_cycles_q != CNT_MAX)) ?
                     stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_RUN;
      flush_pending_q <= 1'b0;
      wait_cnt_q      <= '0;
      stall_cycles_q  <= '0;
      mem_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      wait_cnt_q      <= wait_cnt_d;
      stall_cycles_q  <= stall_cycles_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.ifid_write   = ifid_write_c;
  assign hz.idex_bubble  = idex_bubble_c;
  assign hz.exmem_hold   = exmem_hold_c;
  assign hz.if_flush_out = if_flush_out_c;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.mem_timeout  = mem_timeout_q;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hold/bubble controller for the 5-stage MIPS core; the stall side of pipeline hazard control, complementing the flush path that discards instructions after jump/bne/jr.
- Freezes PC and IF/ID and injects an ID/EX bubble on a load-use hazard.
- Freezes the whole front end while data memory is busy.
- Defers any IF flush request that arrives during a freeze, and keeps a stall-cycle counter and a memory-timeout error flag.

Parameters:
- TIMEOUT, default 255: number of consecutive MEM_WAIT cycles after which mem_timeout is set.
- CNT_W, default 16: width of the saturating stall_cycles counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- mem_req  in  1  EX/MEM stage is performing a data memory access this cycle.
- mem_ready  in  1  data memory has completed the access this cycle.
- if_flush_in  in  1  flush request from the discard logic.
- pc_write  out  1  PC write enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_bubble  out  1  zero ID control into ID/EX (drives the control-zeroing flush input).
- exmem_hold  out  1  hold EX/MEM and MEM/WB registers.
- if_flush_out  out  1  flush actually applied to IF/ID.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset_n=0: state=RUN, flush_pending=0, wait_cnt=0, stall_cycles=0, mem_timeout=0.
  - Outputs forced while reset_n=0: pc_write=0, ifid_write=0, idex_bubble=1, exmem_hold=0, if_flush_out=0.
  - Reset asserted mid-stall aborts the stall immediately; any pending flush is discarded.
- Load-use hazard (combinational), lu:
  - lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Memory busy (combinational): mb = mem_req & ~mem_ready.
- States: RUN, MEM_WAIT. All outputs are Mealy (same-cycle) from state and inputs. There is no added latency.
- RUN, mb=1:
  - pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0, if_flush_out=0.
  - flush_pending <= if_flush_in.
  - Next state = MEM_WAIT; wait_cnt <= 1.
- RUN, mb=0 and lu=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, if_flush_out=0.
  - The flush is suppressed because the branch in ID re-resolves next cycle. Stay in RUN.
- RUN, mb=0 and lu=0:
  - pc_write=1, ifid_write=1, idex_bubble=0, exmem_hold=0, if_flush_out=if_flush_in.
- MEM_WAIT:
  - pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0.
  - flush_pending <= flush_pending | if_flush_in.
  - if_flush_out=0 while mem_ready=0.
  - On mem_ready=1:
    - exmem_hold=0.
    - if_flush_out = flush_pending | if_flush_in; clear flush_pending.
    - pc_write, ifid_write and idex_bubble are then evaluated by the RUN rules using lu, with mb treated as 0.
    - Next state = RUN.
  - A mem_req deasserted without mem_ready is illegal and is treated as mem_ready.
- wait_cnt:
  - Increments each MEM_WAIT cycle, saturating at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, mem_timeout <= 1 (sticky until reset).
  - The stall continues after timeout.
- stall_cycles:
  - Increments on each clock edge where pc_write=0 and reset_n=1.
  - Saturates at all-ones; no wrap.
- Priority order: reset > mem busy > load-use > flush.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle, then ex_memread=0 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
- No false hazard: ex_rt=0, id_rs=0, ex_memread=1 -> pc_write=1, idex_bubble=0. Also ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> exmem_hold=1 for 4 cycles, released in cycle 5; stall_cycles=4.
- Deferred flush: if_flush_in pulses during cycle 2 of a MEM_WAIT -> if_flush_out=0 during the wait, then exactly one cycle of if_flush_out=1 at the mem_ready cycle.
- Load-use with simultaneous flush: lu=1 and if_flush_in=1 -> if_flush_out=0 and idex_bubble=1 that cycle. Next cycle lu=0, if_flush_in=1 -> if_flush_out=1.
- Timeout and reset: TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4 wait cycles. Then assert reset_n=0 mid-wait -> asynchronously mem_timeout=0, stall_cycles=0, idex_bubble=1, pc_write=0.
